inst_decode: RTL and testbench
==============================

# inst_decode

Decode and issue stage sitting directly downstream of instruction fetch (program counter plus instruction ROM). It decodes the 9-bit instruction currently presented by the ROM. It drives the branch controls back to the program counter combinationally, and registers datapath controls into the execute pipeline register. A three-state run controller tracks program start, halt and completion, and counts retired instructions per program.

## Interface
- CNT_W, default 16: width of the retired-instruction counter.
- NPROG, default 3: number of programs held in ROM; sets the ProgId wrap point.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request to run the next program; level-sampled on Clk.
- InstOut  in  9  instruction from ROM at the current ProgCtr.
- ALU_flag  in  1  branch condition from ALU, valid same cycle.
- BranchRel  out  1  relative-branch request to program counter (combinational).
- BranchAbs  out  1  absolute-branch request to program counter (combinational).
- Target  out  10  branch offset or absolute address (combinational).
- ExValid  out  1  execute register holds a live instruction.
- ExAluOp  out  3  ALU function.
- ExReg  out  3  register index.
- ExImm  out  6  immediate field.
- ExRegWrite, ExMemRead, ExMemWrite  out  1 each  datapath enables.
- Done  out  1  program finished, awaiting Start.
- ProgId  out  2  index of the program currently or last run.
- InstCount  out  CNT_W  instructions retired in the current or last program.

## Operation
- Encoding: op = InstOut[8:6].
  - 000 ALU: func = [5:3], reg = [2:0], RegWrite.
  - 001 LDI: imm = [5:0] into r0, RegWrite.
  - 010 LD: reg = [2:0], MemRead, RegWrite.
  - 011 ST: reg = [2:0], MemWrite.
  - 100 MOV: reg = [2:0], RegWrite.
  - 101 BRF: BranchRel = 1, Target = sign-extend([5:0]) to 10 bits. The program counter qualifies the branch with ALU_flag.
  - 110 JMP: BranchAbs = 1, Target = JumpLut[[3:0]].
  - 111: 9'h1FF is HALT; all other 111 encodings are NOP.
- States:
  - IDLE: entered on reset.
  - RUN: decoding.
  - DONE: program halted.
- Transitions:
  - IDLE or DONE with Start=1 → RUN. On entry, InstCount ← 0. From DONE, ProgId ← ProgId+1, wrapping NPROG−1 → 0. From IDLE, ProgId stays 0.
  - RUN with HALT decoded → DONE; Done=1 from the following cycle.
  - Start while in RUN: ignored.
  - HALT and Start in the same cycle: HALT wins. Start must be seen again while in DONE.
- Branch outputs are asserted only in RUN. They are 0 in IDLE and DONE, and Target is 0 whenever no branch is decoded.
- Execute register:
  - In RUN, loads the decoded fields every cycle with ExValid=1.
  - For HALT and NOP: ExValid=1 with all enables 0.
  - Outside RUN: ExValid=0 and all enables 0.
- InstCount increments once per RUN cycle, including the HALT cycle, and saturates at all-ones. It holds its value in DONE.
- JMP index beyond populated LUT entries returns 10'd0.

## Timing
- Reset (asynchronous) values:
  - State = IDLE.
  - All Ex* outputs = 0.
  - Done = 0, ProgId = 0, InstCount = 0.
  - Branch outputs = 0.
- Branch path: InstOut → BranchRel/BranchAbs/Target is combinational within one cycle. The program counter updates on the same edge, so there is no wrong-path fetch and no flush.
- Execute register latency: 1 cycle. Ex* at cycle n+1 reflects InstOut at cycle n.
- IDLE/DONE → RUN takes effect on the edge that samples Start=1. The program counter loads the program start on that same edge, so the first RUN cycle decodes the program's first instruction.
- Reset asserted mid-RUN returns to IDLE immediately. A pending branch is dropped because its combinational outputs go to 0.

## Structure
- Package isa_pkg holds:
  - the opcode enum;
  - the HALT constant 9'h1FF;
  - the state enum {IDLE, RUN, DONE};
  - the 16×10 JumpLut constant array.
- Sub-module jump_lut: combinational, 4-bit index in, 10-bit address out. It is kept separate so the LUT contents can be regenerated by the assembler.

## Test plan
- Reset with Start=0 for 3 cycles → state IDLE, Done=0, ExValid=0, BranchRel=BranchAbs=0, InstCount=0.
- Start=1, then InstOut=9'b001000101 (LDI 5) → next cycle ExValid=1, ExRegWrite=1, ExImm=6'd5, ExMemWrite=0.
- RUN with InstOut=9'b101111110 (BRF −2) → same cycle BranchRel=1, Target=10'h3FE. Repeat with InstOut=9'b110000011 → BranchAbs=1, Target=JumpLut[3].
- Run 4 instructions, then InstOut=9'h1FF → Done=1 the next cycle, InstCount=5, and BranchRel=BranchAbs=0 with arbitrary InstOut while in DONE.
- In DONE, assert Start → RUN, ProgId=1, InstCount=0. Repeat twice more → ProgId wraps from 2 to 0.
- HALT and Start together → DONE and Start ignored. Separately, assert Reset mid-RUN during a BRF → branch outputs drop immediately and all outputs return to reset values.

Source files
------------

// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the decode/issue stage.
//   - opcode_t   : 3-bit major opcode in InstOut[8:6]
//   - HALT_INST  : the single 111-class encoding that ends a program
//   - state_t    : run controller states
//   - ex_ctrl_t  : datapath controls carried into the execute register
//   - JUMP_LUT   : absolute jump targets indexed by InstOut[3:0]
package isa_pkg;

   typedef enum logic [2:0] {
      OP_ALU = 3'b000,
      OP_LDI = 3'b001,
      OP_LD  = 3'b010,
      OP_ST  = 3'b011,
      OP_MOV = 3'b100,
      OP_BRF = 3'b101,
      OP_JMP = 3'b110,
      OP_SYS = 3'b111
   } opcode_t;

   localparam logic [8:0] HALT_INST = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] alu_op;
      logic [2:0] reg_idx;
      logic [5:0] imm;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
   } ex_ctrl_t;

   // Entries 8..15 are unpopulated and resolve to address 0.
   localparam logic [9:0] JUMP_LUT [16] = '{
      10'h010, 10'h020, 10'h040, 10'h080,
      10'h100, 10'h155, 10'h2AA, 10'h3F0,
      10'h000, 10'h000, 10'h000, 10'h000,
      10'h000, 10'h000, 10'h000, 10'h000
   };

endpackage

// File: rtl/jump_lut.sv
// jump_lut: combinational absolute-jump target table. Kept as its own
// module so the assembler can regenerate the table contents.
//   idx  in  4   : JMP index field
//   addr out 10  : absolute target address
module jump_lut
   import isa_pkg::*;
(
   input  logic [3:0] idx,
   output logic [9:0] addr
);

   assign addr = JUMP_LUT[idx];

endmodule

// File: rtl/inst_decode.sv
// inst_decode: decode and issue stage behind instruction fetch.
//   Clk, Reset (async, active-high), Start (level-sampled run request)
//   InstOut [8:0]    : instruction from ROM
//   ALU_flag         : branch condition; qualified by the program counter
//   BranchRel/BranchAbs/Target : combinational branch controls to the PC
//   Ex*              : execute pipeline register (1-cycle latency)
//   Done, ProgId, InstCount    : run controller status
module inst_decode
   import isa_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int NPROG = 3
)(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [8:0]       InstOut,
   input  logic             ALU_flag,
   output logic             BranchRel,
   output logic             BranchAbs,
   output logic [9:0]       Target,
   output logic             ExValid,
   output logic [2:0]       ExAluOp,
   output logic [2:0]       ExReg,
   output logic [5:0]       ExImm,
   output logic             ExRegWrite,
   output logic             ExMemRead,
   output logic             ExMemWrite,
   output logic             Done,
   output logic [1:0]       ProgId,
   output logic [CNT_W-1:0] InstCount
);

   localparam logic [1:0] LAST_PROG = 2'(NPROG - 1);

   // The flag is consumed by the program counter, not here.
   logic unused_alu_flag;
   assign unused_alu_flag = ALU_flag;

   state_t     state, state_nxt;
   opcode_t    op;
   logic       is_halt;
   logic       in_run;
   logic       enter_run;
   ex_ctrl_t   dec;
   ex_ctrl_t   ex;
   logic       ex_valid;
   logic [9:0] lut_addr;
   logic [1:0] prog_id;
   logic [CNT_W-1:0] inst_count;

   assign op      = opcode_t'(InstOut[8:6]);
   assign is_halt = (InstOut == HALT_INST);
   assign in_run  = (state == RUN);

   jump_lut u_jump_lut (
      .idx  (InstOut[3:0]),
      .addr (lut_addr)
   );

   // Branch controls: gated by RUN so nothing leaks out of IDLE/DONE or
   // while reset forces the state back to IDLE.
   always_comb begin
      BranchRel = 1'b0;
      BranchAbs = 1'b0;
      Target    = 10'd0;
      if (in_run) begin
         if (op == OP_BRF) begin
            BranchRel = 1'b1;
            Target    = {{4{InstOut[5]}}, InstOut[5:0]};
         end else if (op == OP_JMP) begin
            BranchAbs = 1'b1;
            Target    = lut_addr;
         end
      end
   end

   // Datapath field decode; branches, HALT and NOP leave everything at 0.
   always_comb begin
      dec = '0;
      unique case (op)
         OP_ALU: begin
            dec.alu_op    = InstOut[5:3];
            dec.reg_idx   = InstOut[2:0];
            dec.reg_write = 1'b1;
         end
         OP_LDI: begin
            dec.imm       = InstOut[5:0];
            dec.reg_idx   = 3'd0;
            dec.reg_write = 1'b1;
         end
         OP_LD: begin
            dec.reg_idx   = InstOut[2:0];
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
         end
         OP_ST: begin
            dec.reg_idx   = InstOut[2:0];
            dec.mem_write = 1'b1;
         end
         OP_MOV: begin
            dec.reg_idx   = InstOut[2:0];
            dec.reg_write = 1'b1;
         end
         default: dec = '0;
      endcase
   end

   // Run controller next state. HALT is checked in RUN only, and Start is
   // not looked at in RUN, so HALT wins when both arrive together.
   always_comb begin
      state_nxt = state;
      enter_run = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (Start) begin
               state_nxt = RUN;
               enter_run = 1'b1;
            end
         end
         RUN: begin
            if (is_halt) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         prog_id    <= 2'd0;
         inst_count <= '0;
      end else begin
         state <= state_nxt;
         // Only a restart from DONE advances the program index.
         if (enter_run && state == DONE)
            prog_id <= (prog_id == LAST_PROG) ? 2'd0 : prog_id + 2'd1;
         if (enter_run)
            inst_count <= '0;
         else if (in_run && inst_count != {CNT_W{1'b1}})
            inst_count <= inst_count + 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ex_valid <= 1'b0;
         ex       <= '0;
      end else if (in_run) begin
         ex_valid <= 1'b1;
         ex       <= dec;
      end else begin
         ex_valid <= 1'b0;
         ex       <= '0;
      end
   end

   assign ExValid    = ex_valid;
   assign ExAluOp    = ex.alu_op;
   assign ExReg      = ex.reg_idx;
   assign ExImm      = ex.imm;
   assign ExRegWrite = ex.reg_write;
   assign ExMemRead  = ex.mem_read;
   assign ExMemWrite = ex.mem_write;
   assign Done       = (state == DONE);
   assign ProgId     = prog_id;
   assign InstCount  = inst_count;

endmodule

// File: tb/tb_inst_decode.sv
module tb_inst_decode;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [8:0]  InstOut = 9'd0;
   logic        ALU_flag = 1'b0;
   logic        BranchRel, BranchAbs;
   logic [9:0]  Target;
   logic        ExValid;
   logic [2:0]  ExAluOp, ExReg;
   logic [5:0]  ExImm;
   logic        ExRegWrite, ExMemRead, ExMemWrite;
   logic        Done;
   logic [1:0]  ProgId;
   logic [15:0] InstCount;

   int checks = 0;
   int errors = 0;

   inst_decode #(.CNT_W(16), .NPROG(3)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .InstOut(InstOut),
      .ALU_flag(ALU_flag), .BranchRel(BranchRel), .BranchAbs(BranchAbs),
      .Target(Target), .ExValid(ExValid), .ExAluOp(ExAluOp), .ExReg(ExReg),
      .ExImm(ExImm), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
      .ExMemWrite(ExMemWrite), .Done(Done), .ProgId(ProgId),
      .InstCount(InstCount)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; InstOut = 9'b101111110;
      repeat (3) step();
      Reset = 1'b0;
      #1;
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
      checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL reset_exvalid got %b want 0", ExValid); end
      checks++; if ({BranchRel, BranchAbs} !== 2'b00) begin errors++; $display("FAIL reset_branch got %b want 00", {BranchRel, BranchAbs}); end
      checks++; if (InstCount !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", InstCount); end
      checks++; if (ProgId !== 2'd0) begin errors++; $display("FAIL reset_progid got %0d want 0", ProgId); end
      $display("reset: Done=%b ExValid=%b Count=%0d", Done, ExValid, InstCount);
   endtask

   task automatic test_ldi();
      Start = 1'b1; step();
      Start = 1'b0; InstOut = 9'b001000101; step();
      checks++; if (ExValid !== 1'b1) begin errors++; $display("FAIL ldi_valid got %b want 1", ExValid); end
      checks++; if (ExRegWrite !== 1'b1) begin errors++; $display("FAIL ldi_regwrite got %b want 1", ExRegWrite); end
      checks++; if (ExImm !== 6'd5) begin errors++; $display("FAIL ldi_imm got %0d want 5", ExImm); end
      checks++; if (ExMemWrite !== 1'b0) begin errors++; $display("FAIL ldi_memwrite got %b want 0", ExMemWrite); end
      checks++; if (ExReg !== 3'd0) begin errors++; $display("FAIL ldi_reg got %0d want 0", ExReg); end
      $display("ldi: ExValid=%b ExImm=%0d", ExValid, ExImm);
   endtask

   task automatic test_branch();
      InstOut = 9'b101111110; #1;
      checks++; if (BranchRel !== 1'b1 || BranchAbs !== 1'b0) begin errors++; $display("FAIL brf_req got %b%b want 10", BranchRel, BranchAbs); end
      checks++; if (Target !== 10'h3FE) begin errors++; $display("FAIL brf_target got %h want 3fe", Target); end
      step();
      checks++; if (ExValid !== 1'b1 || ExRegWrite !== 1'b0) begin errors++; $display("FAIL brf_ex got %b%b want 10", ExValid, ExRegWrite); end
      InstOut = 9'b110000011; #1;
      checks++; if (BranchAbs !== 1'b1 || BranchRel !== 1'b0) begin errors++; $display("FAIL jmp_req got %b%b want 01", BranchRel, BranchAbs); end
      checks++; if (Target !== 10'h080) begin errors++; $display("FAIL jmp3_target got %h want 080", Target); end
      step();
      InstOut = 9'b110001100; #1;
      checks++; if (BranchAbs !== 1'b1 || Target !== 10'h000) begin errors++; $display("FAIL jmp12 got %b/%h want 1/000", BranchAbs, Target); end
      step();
      $display("branch: rel/abs targets checked");
   endtask

   task automatic test_datapath();
      InstOut = 9'b000011101; step();
      checks++; if (ExAluOp !== 3'd3 || ExReg !== 3'd5 || ExRegWrite !== 1'b1) begin errors++; $display("FAIL alu got op%0d r%0d w%b want op3 r5 w1", ExAluOp, ExReg, ExRegWrite); end
      InstOut = 9'b011000010; step();
      checks++; if (ExMemWrite !== 1'b1 || ExRegWrite !== 1'b0 || ExReg !== 3'd2) begin errors++; $display("FAIL st got mw%b rw%b r%0d want 1 0 2", ExMemWrite, ExRegWrite, ExReg); end
      InstOut = 9'b010000100; step();
      checks++; if (ExMemRead !== 1'b1 || ExRegWrite !== 1'b1 || ExReg !== 3'd4) begin errors++; $display("FAIL ld got mr%b rw%b r%0d want 1 1 4", ExMemRead, ExRegWrite, ExReg); end
      InstOut = 9'b111000000; step();
      checks++; if (ExValid !== 1'b1 || {ExRegWrite, ExMemRead, ExMemWrite} !== 3'b000) begin errors++; $display("FAIL nop got v%b en%b want v1 en000", ExValid, {ExRegWrite, ExMemRead, ExMemWrite}); end
      InstOut = 9'h1FF; step();
      checks++; if (Done !== 1'b1 || InstCount !== 16'd9) begin errors++; $display("FAIL halt0 got done%b cnt%0d want 1 9", Done, InstCount); end
      $display("datapath: program 0 halted count=%0d", InstCount);
   endtask

   task automatic test_prog_cycle();
      Start = 1'b1; step();
      Start = 1'b0;
      checks++; if (ProgId !== 2'd1 || InstCount !== 16'd0 || Done !== 1'b0) begin errors++; $display("FAIL start1 got id%0d cnt%0d done%b want 1 0 0", ProgId, InstCount, Done); end
      InstOut = 9'b100000001; step();
      InstOut = 9'b001000111; step();
      InstOut = 9'b000001010; step();
      InstOut = 9'b011000011; step();
      InstOut = 9'h1FF; step();
      checks++; if (Done !== 1'b1 || InstCount !== 16'd5) begin errors++; $display("FAIL halt1 got done%b cnt%0d want 1 5", Done, InstCount); end
      InstOut = 9'b101111110; #1;
      checks++; if (BranchRel !== 1'b0 || Target !== 10'd0) begin errors++; $display("FAIL done_brf got %b/%h want 0/000", BranchRel, Target); end
      InstOut = 9'b110000011; #1;
      checks++; if (BranchAbs !== 1'b0 || Target !== 10'd0) begin errors++; $display("FAIL done_jmp got %b/%h want 0/000", BranchAbs, Target); end
      step();
      checks++; if (ExValid !== 1'b0 || InstCount !== 16'd5) begin errors++; $display("FAIL done_hold got v%b cnt%0d want 0 5", ExValid, InstCount); end
      Start = 1'b1; step();
      checks++; if (ProgId !== 2'd2) begin errors++; $display("FAIL start2 got %0d want 2", ProgId); end
      InstOut = 9'h1FF; step();
      Start = 1'b0;
      checks++; if (Done !== 1'b1 || InstCount !== 16'd1) begin errors++; $display("FAIL halt_start got done%b cnt%0d want 1 1", Done, InstCount); end
      step();
      checks++; if (Done !== 1'b1 || ProgId !== 2'd2) begin errors++; $display("FAIL start_ignored got done%b id%0d want 1 2", Done, ProgId); end
      Start = 1'b1; step();
      Start = 1'b0;
      checks++; if (ProgId !== 2'd0 || Done !== 1'b0) begin errors++; $display("FAIL wrap got id%0d done%b want 0 0", ProgId, Done); end
      $display("prog_cycle: ProgId wrapped to %0d", ProgId);
   endtask

   task automatic test_reset_mid_run();
      InstOut = 9'b101000011; ALU_flag = 1'b1; #1;
      checks++; if (BranchRel !== 1'b1 || Target !== 10'd3) begin errors++; $display("FAIL brf_pos got %b/%h want 1/003", BranchRel, Target); end
      step();
      #1 Reset = 1'b1; #1;
      checks++; if (BranchRel !== 1'b0 || Target !== 10'd0) begin errors++; $display("FAIL rst_branch got %b/%h want 0/000", BranchRel, Target); end
      checks++; if (ExValid !== 1'b0 || ExRegWrite !== 1'b0 || InstCount !== 16'd0 || ProgId !== 2'd0 || Done !== 1'b0) begin errors++; $display("FAIL rst_outputs got v%b w%b c%0d id%0d d%b want all 0", ExValid, ExRegWrite, InstCount, ProgId, Done); end
      step();
      Reset = 1'b0;
      $display("reset_mid_run: outputs cleared");
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_branch();
      test_datapath();
      test_prog_cycle();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
